// File: rtl/branch_predictor_gshare_pkg.sv
// Shared constants and types for the gshare predictor: counter init/saturation
// helpers and the BTB entry record.
package branch_predictor_gshare_pkg;

  // Wide enough for any legal IDX_W/TAG_W pairing; narrower tags are zero-extended.
  localparam int MAX_TAG_W = 30;

  typedef struct packed {
    logic                 is_jump;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  function automatic int cnt_init(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_sat_counter_bank.sv
// Array of saturating direction counters; reads are combinational and see the
// pre-update value, writes land on the clock edge.
module sat_counter_bank
  import branch_predictor_gshare_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int CNT_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
  output logic                       rd_msb_o,
  input  logic                       upd_en_i,
  input  logic [$clog2(ENTRIES)-1:0] upd_idx_i,
  input  logic                       upd_taken_i
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q[upd_idx_i];
    if (upd_taken_i) begin
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + 1'b1;
    end else begin
      if (cnt_d != '0) cnt_d = cnt_d - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= cnt_d;
    end
  end

  assign rd_msb_o = cnt_q[rd_idx_i][CNT_W-1];

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor with a direct-mapped BTB; zero-cycle fetch lookup,
// EX-stage resolution drives flush/redirect and trains the tables.
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int CNT_W   = 2,
  parameter int GHIST   = 8,
  parameter int TAG_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                pc_F,
  input  logic [31:0]                pc4_F,
  output logic [31:0]                pc_next,
  output logic                       taken_F,
  output logic [$clog2(ENTRIES)-1:0] idx_F,
  input  logic [$clog2(ENTRIES)-1:0] idx_E,
  input  logic [31:0]                pc_E,
  input  logic [31:0]                pc4_E,
  input  logic [31:0]                pc_D,
  input  logic [31:0]                pc_target,
  input  logic                       branch_E,
  input  logic                       jump_E,
  input  logic                       taken_E,
  input  logic                       branch,
  output logic                       flush,
  output logic [31:0]                pc_restore
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]   hist;
  logic [ENTRIES-1:0] valid_q, valid_d;
  btb_entry_t         btb_q [ENTRIES];
  btb_entry_t         rd_entry, wr_entry;
  logic [TAG_W-1:0]   tag_F, tag_E;
  logic               cnt_msb, hit_F;
  logic               actual, ctrl_E, alias_E;
  logic               unused_pc;

  assign unused_pc = ^{pc_F, pc_E};

  assign actual  = jump_E | (branch_E & branch);
  assign ctrl_E  = branch_E | jump_E;
  assign alias_E = ~ctrl_E & taken_E;

  // History only advances on resolved conditional branches, never speculatively.
  if (GHIST > 0) begin : g_hist
    logic [GHIST-1:0] ghr_q, ghr_d;

    always_comb begin
      ghr_d = ghr_q;
      if (branch_E) ghr_d = (ghr_q << 1) | GHIST'(actual);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ghr_q <= '0;
      else        ghr_q <= ghr_d;
    end

    assign hist = IDX_W'(ghr_q);
  end else begin : g_bimodal
    assign hist = '0;
  end

  assign idx_F = pc_F[IDX_W+1:2] ^ hist;
  assign tag_F = pc_F[IDX_W+TAG_W+1:IDX_W+2];
  assign tag_E = pc_E[IDX_W+TAG_W+1:IDX_W+2];

  sat_counter_bank #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (idx_F),
    .rd_msb_o    (cnt_msb),
    .upd_en_i    (branch_E),
    .upd_idx_i   (idx_E),
    .upd_taken_i (branch)
  );

  assign rd_entry = btb_q[idx_F];
  assign hit_F    = valid_q[idx_F] & (rd_entry.tag == MAX_TAG_W'(tag_F));
  assign taken_F  = hit_F & (cnt_msb | rd_entry.is_jump);
  assign pc_next  = taken_F ? rd_entry.target : pc4_F;

  assign flush = (ctrl_E & (actual != taken_E))
               | (actual & taken_E & (pc_D != pc_target))
               | alias_E;
  assign pc_restore = actual ? pc_target : pc4_E;

  always_comb begin
    valid_d = valid_q;
    if (actual)       valid_d[idx_E] = 1'b1;
    else if (alias_E) valid_d[idx_E] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  assign wr_entry = '{is_jump: jump_E, tag: MAX_TAG_W'(tag_E), target: pc_target};

  // Target/tag storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (actual) btb_q[idx_E] <= wr_entry;
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench for branch_predictor_gshare: directed scenarios plus a
// randomized run against an array-based reference model.
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc_F, pc4_F, pc_next, pc_E, pc4_E, pc_D, pc_target, pc_restore;
  logic [7:0]  idx_F, idx_E;
  logic        taken_F, branch_E, jump_E, taken_E, branch, flush;

  logic [31:0] s_pc_F, s_pc4_F, s_pc_next, s_pc_E, s_pc_target, s_pc_restore;
  logic [3:0]  s_idx_F, s_idx_E;
  logic        s_taken_F, s_branch_E, s_taken_E, s_branch, s_flush;

  int vectors = 0;
  int miscompares = 0;

  branch_predictor_gshare dut (
    .clk(clk), .rst_n(rst_n), .pc_F(pc_F), .pc4_F(pc4_F), .pc_next(pc_next),
    .taken_F(taken_F), .idx_F(idx_F), .idx_E(idx_E), .pc_E(pc_E), .pc4_E(pc4_E),
    .pc_D(pc_D), .pc_target(pc_target), .branch_E(branch_E), .jump_E(jump_E),
    .taken_E(taken_E), .branch(branch), .flush(flush), .pc_restore(pc_restore)
  );

  branch_predictor_gshare #(.ENTRIES(16), .GHIST(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .pc_F(s_pc_F), .pc4_F(s_pc4_F), .pc_next(s_pc_next),
    .taken_F(s_taken_F), .idx_F(s_idx_F), .idx_E(s_idx_E), .pc_E(s_pc_E), .pc4_E(32'h0),
    .pc_D(s_pc_target), .pc_target(s_pc_target), .branch_E(s_branch_E), .jump_E(1'b0),
    .taken_E(s_taken_E), .branch(s_branch), .flush(s_flush), .pc_restore(s_pc_restore)
  );

  // Reference model: one record per table slot plus an integer history.
  int          m_cnt [256];
  bit          m_val [256];
  int unsigned m_tag [256];
  logic [31:0] m_tgt [256];
  bit          m_jmp [256];
  int unsigned m_ghr;

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return ((pc >> 2) ^ m_ghr) & 255;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 256; i++) begin
      m_cnt[i] = 1;
      m_val[i] = 1'b0;
    end
    m_ghr = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic idle();
    branch_E = 0; jump_E = 0; taken_E = 0; branch = 0;
    pc_E = 0; pc4_E = 4; pc_D = 0; pc_target = 0; idx_E = 0;
  endtask

  task automatic set_f(input logic [31:0] pc);
    pc_F = pc;
    pc4_F = pc + 4;
  endtask

  // Check every output against the model, then clock and train the model.
  task automatic step(input string nm);
    int unsigned i;
    bit hit, t, actual, ctrl, alias_e, exp_flush;
    logic [31:0] exp_next, exp_rest;
    pc4_F = pc_F + 4;
    #1;
    i = m_idx(pc_F);
    hit = m_val[i] && (m_tag[i] == ((pc_F >> 10) & 255));
    t = hit && (m_cnt[i] >= 2 || m_jmp[i]);
    exp_next = t ? m_tgt[i] : pc_F + 4;
    actual = jump_E || (branch_E && branch);
    ctrl = branch_E || jump_E;
    alias_e = !ctrl && taken_E;
    exp_flush = (ctrl && (actual != taken_E)) || (actual && taken_E && (pc_D != pc_target)) || alias_e;
    exp_rest = actual ? pc_target : pc4_E;
    chk({nm, ":idx_F"}, 32'(idx_F), i);
    chk({nm, ":taken_F"}, 32'(taken_F), 32'(t));
    chk({nm, ":pc_next"}, pc_next, exp_next);
    chk({nm, ":flush"}, 32'(flush), 32'(exp_flush));
    chk({nm, ":pc_restore"}, pc_restore, exp_rest);
    @(posedge clk);
    if (branch_E) begin
      if (branch) m_cnt[idx_E] = (m_cnt[idx_E] < 3) ? m_cnt[idx_E] + 1 : 3;
      else        m_cnt[idx_E] = (m_cnt[idx_E] > 0) ? m_cnt[idx_E] - 1 : 0;
      m_ghr = ((m_ghr << 1) | 32'(actual)) & 255;
    end
    if (actual) begin
      m_val[idx_E] = 1'b1;
      m_tag[idx_E] = (pc_E >> 10) & 255;
      m_tgt[idx_E] = pc_target;
      m_jmp[idx_E] = jump_E;
    end else if (alias_e) begin
      m_val[idx_E] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int unsigned k;
    int unsigned kind;
    idle();
    set_f(32'h100);
    s_pc_F = 0; s_pc4_F = 4; s_pc_E = 0; s_pc_target = 0; s_idx_E = 0;
    s_branch_E = 0; s_taken_E = 0; s_branch = 0;
    m_reset();
    branch_E = 1; branch = 1; pc_E = 32'h100; idx_E = 8'h40; pc_target = 32'h180;
    #1;
    chk("rst_taken_F", 32'(taken_F), 0);
    chk("rst_pc_next", pc_next, 32'h104);
    chk("rst_flush", 32'(flush), 1);
    @(negedge clk);
    @(negedge clk);
    idle();
    rst_n = 1;
    #1;
    chk("rst_ghr", 32'(dut.g_hist.ghr_q), 0);
    chk("rst_cnt", 32'(dut.u_cnt.cnt_q[8'h40]), 1);
    @(negedge clk);

    // Saturation: 5 taken then 4 not-taken at one slot.
    for (int n = 0; n < 9; n++) begin
      idle();
      branch_E = 1; branch = (n < 5); taken_E = (n < 5);
      pc_E = 32'h100; pc4_E = 32'h104; pc_target = 32'h180; pc_D = 32'h180; idx_E = 8'h40;
      set_f(32'h100);
      step("sat");
      chk("sat_cnt", 32'(dut.u_cnt.cnt_q[8'h40]), 32'(m_cnt[8'h40]));
      if (n == 4) chk("sat_hi", 32'(dut.u_cnt.cnt_q[8'h40]), 3);
    end
    chk("sat_lo", 32'(dut.u_cnt.cnt_q[8'h40]), 0);

    // Cold mispredict then trained lookup.
    do_reset();
    idle();
    branch_E = 1; branch = 1; taken_E = 0; pc_E = 32'h40; pc4_E = 32'h44;
    pc_target = 32'h80; pc_D = 32'h44; idx_E = 8'h13; set_f(32'h0);
    #1;
    chk("cold_flush", 32'(flush), 1);
    chk("cold_restore", pc_restore, 32'h80);
    step("cold1");
    taken_E = 1; pc_D = 32'h80;
    step("cold2");
    idle(); set_f(32'h40);
    #1;
    chk("cold_taken_F", 32'(taken_F), 1);
    chk("cold_pc_next", pc_next, 32'h80);
    step("cold_lookup");

    // Jump with a stale predicted target.
    idle();
    jump_E = 1; taken_E = 0; pc_E = 32'h500; pc4_E = 32'h504; pc_target = 32'h200;
    pc_D = 32'h504; idx_E = 8'(m_idx(32'h500)); k = m_idx(32'h500);
    step("jmp_install");
    taken_E = 1; pc_D = 32'h200; pc_target = 32'h300;
    #1;
    chk("tgt_flush", 32'(flush), 1);
    chk("tgt_restore", pc_restore, 32'h300);
    step("jmp_retarget");
    idle(); set_f(32'h500);
    #1;
    chk("tgt_taken_F", 32'(taken_F), 1);
    chk("tgt_pc_next", pc_next, 32'h300);
    step("tgt_lookup");

    // Alias: prediction on a non-control instruction.
    idle();
    taken_E = 1; pc4_E = 32'h24; idx_E = 8'(k);
    #1;
    chk("alias_flush", 32'(flush), 1);
    chk("alias_restore", pc_restore, 32'h24);
    step("alias");
    idle(); set_f(32'h500);
    #1;
    chk("alias_taken_F", 32'(taken_F), 0);
    chk("alias_pc_next", pc_next, 32'h504);
    step("alias_lookup");

    for (int n = 0; n < 400; n++) begin
      idle();
      kind = $urandom_range(0, 3);
      pc_E = ($urandom_range(0, 1) << 10) | ($urandom_range(0, 7) << 2);
      pc4_E = pc_E + 4;
      idx_E = 8'(m_idx(pc_E));
      if ($urandom_range(0, 1) == 1) set_f(pc_E);
      else set_f(($urandom_range(0, 1) << 10) | ($urandom_range(0, 7) << 2));
      branch_E = (kind == 1); jump_E = (kind == 2);
      taken_E = 1'($urandom_range(0, 1)); branch = 1'($urandom_range(0, 1));
      pc_target = $urandom_range(1, 255) << 2;
      pc_D = ($urandom_range(0, 1) == 1) ? pc_target : pc_target + 4;
      step("rnd");
    end

    // Reset asserted mid-cycle while a taken branch is resolving.
    idle();
    branch_E = 1; branch = 1; taken_E = 1; pc_E = 32'h40; pc4_E = 32'h44;
    pc_target = 32'h80; pc_D = 32'h80; idx_E = 8'(m_idx(32'h40)); k = m_idx(32'h40);
    set_f(32'h40);
    #2;
    rst_n = 0;
    m_reset();
    #1;
    chk("mid_taken_F", 32'(taken_F), 0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1;
    #1;
    chk("mid_ghr", 32'(dut.g_hist.ghr_q), 0);
    chk("mid_cnt", 32'(dut.u_cnt.cnt_q[k]), 1);
    set_f(32'h40);
    step("mid_lookup");

    // Bimodal 16-entry build: index is pc[5:2]; 0x00 and 0x40 collide.
    s_branch_E = 1; s_branch = 1; s_pc_E = 32'h0; s_pc_target = 32'h80; s_idx_E = 0;
    @(posedge clk);
    @(negedge clk);
    s_branch_E = 0; s_branch = 0; s_pc_F = 32'h0; s_pc4_F = 32'h4;
    #1;
    chk("b16_idx0", 32'(s_idx_F), 0);
    chk("b16_hit", 32'(s_taken_F), 1);
    chk("b16_hit_next", s_pc_next, 32'h80);
    s_pc_F = 32'h40; s_pc4_F = 32'h44;
    #1;
    chk("b16_alias_idx", 32'(s_idx_F), 0);
    chk("b16_tag_miss", 32'(s_taken_F), 0);
    chk("b16_miss_next", s_pc_next, 32'h44);
    s_pc_F = 32'h3C; s_pc4_F = 32'h40;
    #1;
    chk("b16_idx_f", 32'(s_idx_F), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 SHALL have parameter ENTRIES, default 256, meaning the number of BHT/BTB entries; it SHALL be a power of two from 16 to 4096.
REQ-002 SHALL have parameter CNT_W, default 2, meaning the saturating counter width; legal range 1..4.
REQ-003 SHALL have parameter GHIST, default 8, meaning the global history length; 0 means plain bimodal, and GHIST SHALL NOT exceed IDX_W.
REQ-004 SHALL have parameter TAG_W, default 8, meaning the number of BTB tag bits taken from pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-005 SHALL use derived localparam IDX_W = clog2(ENTRIES).
REQ-006 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- pc_F  in  32  fetch PC.
- pc4_F  in  32  fetch PC+4.
- pc_next  out  32  predicted next fetch PC.
- taken_F  out  1  predicted taken.
- idx_F  out  IDX_W  lookup index, carried down the pipe.
- idx_E  in  IDX_W  index of the instruction in EX.
- pc_E, pc4_E, pc_D, pc_target  in  32 each  EX PC, EX PC+4, PC of the instruction in ID, resolved target.
- branch_E, jump_E, taken_E, branch  in  1 each  EX is a branch, EX is jal/jalr, prediction made for EX, ALU branch condition.
- flush  out  1  mispredict.
- pc_restore  out  32  redirect PC.

Function
REQ-007 SHALL compute idx_F = pc_F[IDX_W+1:2] XOR zero-extended ghr[GHIST-1:0] (no XOR when GHIST=0), combinationally.
REQ-008 SHALL assert taken_F when btb_valid[idx_F] is set, the tag matches, and either the counter MSB = 1 or the entry's is_jump bit is set; otherwise it SHALL deassert taken_F.
REQ-009 SHALL drive pc_next = btb_target[idx_F] when taken_F, else pc4_F; lookup latency SHALL be 0 cycles.
REQ-010 SHALL compute actual = jump_E | (branch_E & branch).
REQ-011 SHALL assert flush combinationally in any of these cases:
- (branch_E|jump_E) & (actual != taken_E);
- actual & taken_E & (pc_D != pc_target);
- ~branch_E & ~jump_E & taken_E (alias).
REQ-012 SHALL drive pc_restore = pc_target when actual, else pc4_E.
REQ-013 SHALL, on each clk edge with branch_E, saturate-increment counter[idx_E] if branch, else saturate-decrement; no wrap-around at 0 or 2^CNT_W-1.
REQ-014 SHALL, on each clk edge with actual, write btb_valid=1, tag(pc_E), btb_target=pc_target, and is_jump=jump_E at idx_E.
REQ-015 SHALL, on an alias flush, clear btb_valid[idx_E].
REQ-016 SHALL shift ghr left, inserting actual, only when branch_E; history is non-speculative.
REQ-017 SHALL, when an update and a lookup hit the same index in one cycle, return the pre-update value to the lookup; the new value is visible next cycle.
REQ-018 SHALL leave all state unchanged in cycles with no branch_E/jump_E/taken_E.

Reset
REQ-019 SHALL, on rst_n low, immediately clear btb_valid, ghr, flush-related state; every counter SHALL be set to 2^(CNT_W-1)-1 (weakly not-taken).
REQ-020 SHALL output taken_F=0 and pc_next=pc4_F during and right after reset; flush is then a pure function of inputs.
REQ-021 SHALL not require btb_target or tag storage to be reset.
REQ-022 SHALL abandon any update in flight if reset asserts mid-cycle.

Structure
REQ-023 SHALL place counter-init and saturation constants and the BTB entry record type in the shared core package.
REQ-024 SHALL implement the counter array as one sub-module, sat_counter_bank, with parameters ENTRIES and CNT_W.

Verification
REQ-025 SHALL cover counter saturation: default params, branch at pc_E=0x100 resolved taken 5 times -> counter reaches 3 and stays 3; 4 not-taken -> 0 and stays 0.
REQ-026 SHALL cover cold mispredict: BTB empty, taken branch pc_E=0x40, pc_target=0x80, taken_E=0 -> flush=1, pc_restore=0x80; next lookup at pc_F=0x40 (ghr matched) -> taken_F=1 (after second taken), pc_next=0x80.
REQ-027 SHALL cover a wrong predicted target: jalr with taken_E=1, pc_D=0x200, pc_target=0x300 -> flush=1, pc_restore=0x300, btb_target updated to 0x300.
REQ-028 SHALL cover alias: taken_E=1, branch_E=jump_E=0, pc4_E=0x24 -> flush=1, pc_restore=0x24, entry invalidated.
REQ-029 SHALL cover the GHIST=0 and ENTRIES=16 builds: indices equal pc[5:2], and two PCs 0x00/0x40 collide with tag mismatch -> taken_F=0.
REQ-030 SHALL cover asynchronous reset asserted while branch_E=1 -> no state written, taken_F=0, ghr=0.
